// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forwarding select codes and common widths.
package cpu_pkg;

    // Forwarding source encodings, driven as sel by the hazard unit
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    localparam int unsigned ERRCNT_W_DEFAULT = 16;

    // Select width for an N-input mux, never narrower than one bit
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : cpu_pkg

// File: rtl/fwd_mux_stage_mux_n.sv
// Combinational N:1 mux; out-of-range select codes fall back to DEFAULT_SEL.
module mux_n
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_INPUTS  = 3,
    parameter int unsigned DEFAULT_SEL = 0,
    localparam int unsigned SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            sel,
    output logic [WIDTH-1:0]            picked_c,
    output logic [SEL_W-1:0]            eff_sel_c,
    output logic                        oor_c
);

    // Resolve the effective index, then pick the matching input slice
    always_comb begin
        oor_c     = 1'b0;
        eff_sel_c = sel;
        picked_c  = '0;
        if (32'(sel) >= NUM_INPUTS) begin
            oor_c     = 1'b1;
            eff_sel_c = SEL_W'(DEFAULT_SEL);
        end
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (eff_sel_c == SEL_W'(i)) begin
                picked_c = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule : mux_n

// File: rtl/fwd_mux_stage.sv
// ID/EX operand-select stage: registered N:1 mux with stall, flush and select-error tracking.
module fwd_mux_stage
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_INPUTS  = 3,
    parameter int unsigned DEFAULT_SEL = 0,
    parameter int unsigned ERRCNT_W    = ERRCNT_W_DEFAULT,
    localparam int unsigned SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        in_valid,
    input  logic                        stall,
    input  logic                        flush,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        sel_err,
    output logic [ERRCNT_W-1:0]         err_count
);

    logic [WIDTH-1:0]    picked_c;
    logic [SEL_W-1:0]    eff_sel_c;
    logic                oor_c;
    logic                err_evt_c;

    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
    logic                sel_err_q,   sel_err_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    mux_n #(
        .WIDTH       (WIDTH),
        .NUM_INPUTS  (NUM_INPUTS),
        .DEFAULT_SEL (DEFAULT_SEL)
    ) u_mux (
        .in_data   (in_data),
        .sel       (sel),
        .picked_c  (picked_c),
        .eff_sel_c (eff_sel_c),
        .oor_c     (oor_c)
    );

    // Only a real instruction with a bad select counts as an error
    assign err_evt_c = in_valid & oor_c;

    // Next-state: flush beats stall beats capture; counter saturates
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        sel_err_d   = 1'b0;
        err_count_d = err_count_q;
        if (flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_sel_d   = '0;
        end else if (!stall) begin
            out_data_d  = picked_c;
            out_valid_d = in_valid;
            out_sel_d   = eff_sel_c;
            sel_err_d   = err_evt_c;
            if (err_evt_c && (err_count_q != {ERRCNT_W{1'b1}})) begin
                err_count_d = err_count_q + ERRCNT_W'(1);
            end
        end
    end

    // Output stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign sel_err   = sel_err_q;
    assign err_count = err_count_q;

endmodule : fwd_mux_stage

// File: tb/tb_fwd_mux_stage.sv
// Scoreboard bench: a 3-input/4-bit-counter instance and a 4-input instance run side by side.
module tb_fwd_mux_stage;

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic [1:0]  s;
        logic        e;
        logic [15:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 3 inputs, 4-bit error counter
    logic [95:0] in_a = '0;
    logic [1:0]  sel_a = '0;
    logic        valid_a = 1'b0, stall_a = 1'b0, flush_a = 1'b0;
    logic [31:0] od_a;
    logic        ov_a, err_a;
    logic [1:0]  os_a;
    logic [3:0]  cnt_a;

    // Instance B: 4 inputs (power of two), default counter width
    logic [127:0] in_b = '0;
    logic [1:0]   sel_b = '0;
    logic         valid_b = 1'b0, stall_b = 1'b0, flush_b = 1'b0;
    logic [31:0]  od_b;
    logic         ov_b, err_b;
    logic [1:0]   os_b;
    logic [15:0]  cnt_b;

    fwd_mux_stage #(.WIDTH(32), .NUM_INPUTS(3), .DEFAULT_SEL(0), .ERRCNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_a), .sel(sel_a), .in_valid(valid_a),
        .stall(stall_a), .flush(flush_a), .out_data(od_a), .out_valid(ov_a),
        .out_sel(os_a), .sel_err(err_a), .err_count(cnt_a)
    );

    fwd_mux_stage #(.WIDTH(32), .NUM_INPUTS(4), .DEFAULT_SEL(0), .ERRCNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_b), .sel(sel_b), .in_valid(valid_b),
        .stall(stall_b), .flush(flush_b), .out_data(od_b), .out_valid(ov_b),
        .out_sel(os_b), .sel_err(err_b), .err_count(cnt_b)
    );

    int n_chk = 0;
    int n_pass = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t m_a, m_b;
    int unsigned b_idx = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else n_pass++;
    endtask

    function automatic exp_t zero_exp();
        exp_t z;
        z.d = '0; z.v = 1'b0; z.s = '0; z.e = 1'b0; z.c = '0;
        return z;
    endfunction

    // Reference behaviour of one capture edge
    function automatic exp_t model(input exp_t st, input logic [127:0] din, input int n,
                                   input logic [1:0] s, input logic v, input logic stl,
                                   input logic fl, input logic [15:0] cmax);
        exp_t r = st;
        int   idx;
        logic bad;
        r.e = 1'b0;
        if (fl) begin
            r.d = '0; r.v = 1'b0; r.s = '0;
        end else if (!stl) begin
            bad = (int'(s) >= n);
            idx = bad ? 0 : int'(s);
            r.d = din[idx*32 +: 32];
            r.v = v;
            r.s = 2'(idx);
            r.e = v && bad;
            if (r.e && st.c < cmax) r.c = st.c + 16'd1;
        end
        return r;
    endfunction

    task automatic compare(input string who, input exp_t e, input logic [31:0] d, input logic v,
                           input logic [1:0] s, input logic er, input logic [15:0] c);
        check({who, ".out_data"},  d,        e.d);
        check({who, ".out_valid"}, 32'(v),   32'(e.v));
        check({who, ".out_sel"},   32'(s),   32'(e.s));
        check({who, ".sel_err"},   32'(er),  32'(e.e));
        check({who, ".err_count"}, 32'(c),   32'(e.c));
    endtask

    // Drive one cycle on both instances (called at negedge), then score after the edge
    task automatic step(input logic [1:0] s, input logic v, input logic stl, input logic fl);
        exp_t ea, eb;
        sel_a = s; valid_a = v; stall_a = stl; flush_a = fl;
        sel_b = 2'(b_idx); valid_b = 1'b1; b_idx++;
        in_b  = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_a = model(m_a, {32'd0, in_a}, 3, s, v, stl, fl, 16'd15);
        m_b = model(m_b, in_b, 4, sel_b, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        q_a.push_back(m_a);
        q_b.push_back(m_b);
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        compare("A", ea, od_a, ov_a, os_a, err_a, {12'd0, cnt_a});
        compare("B", eb, od_b, ov_b, os_b, err_b, cnt_b);
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst.A.out_data",  od_a, 32'd0);
        check("rst.A.out_valid", 32'(ov_a), 32'd0);
        check("rst.A.out_sel",   32'(os_a), 32'd0);
        check("rst.A.sel_err",   32'(err_a), 32'd0);
        check("rst.A.err_count", 32'(cnt_a), 32'd0);
        check("rst.B.out_data",  od_b, 32'd0);
        check("rst.B.err_count", 32'(cnt_b), 32'd0);
        m_a = zero_exp();
        m_b = zero_exp();
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_a = zero_exp();
        m_b = zero_exp();
        @(negedge clk);
        do_reset();

        // Basic select
        in_a = {32'h33333333, 32'h22222222, 32'h11111111};
        step(2'd1, 1'b1, 1'b0, 1'b0);

        // Capture sel=2, then stall while inputs and sel change
        step(2'd2, 1'b1, 1'b0, 1'b0);
        in_a = {32'h66666666, 32'h55555555, 32'h44444444};
        repeat (3) step(2'd0, 1'b1, 1'b1, 1'b0);
        step(2'd0, 1'b1, 1'b0, 1'b0);

        // Flush wins over stall, then normal capture resumes
        step(2'd1, 1'b1, 1'b1, 1'b1);
        in_a = {32'h33333333, 32'h22222222, 32'h11111111};
        step(2'd0, 1'b1, 1'b0, 1'b0);

        // Out-of-range select: one pulse, stall does not repeat it, invalid is ignored
        step(2'd3, 1'b1, 1'b0, 1'b0);
        repeat (2) step(2'd3, 1'b1, 1'b1, 1'b0);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0, 1'b0);

        // Reset while stalled discards everything
        stall_a = 1'b1;
        do_reset();

        // Saturation of the 4-bit counter; flush keeps it, reset clears it
        for (int i = 0; i < 20; i++) begin
            in_a[31:0] = $urandom();
            step(2'd3, 1'b1, 1'b0, 1'b0);
        end
        check("sat.err_count", 32'(cnt_a), 32'd15);
        step(2'd0, 1'b1, 1'b0, 1'b1);
        step(2'd1, 1'b1, 1'b0, 1'b0);
        do_reset();

        // A few random cycles mixing all controls
        for (int i = 0; i < 24; i++) begin
            in_a = {$urandom(), $urandom(), $urandom()};
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_fwd_mux_stage

// File: doc/fwd_mux_stage.md
Name: fwd_mux_stage

Overview:
- Parametrised N:1 operand-select mux with a registered output stage, for the ID/EX operand path of the 5-stage pipeline.
- Selects one of NUM_INPUTS forwarded operands and captures the result with a valid bit.
- Honours pipeline stall (hold) and flush (bubble insertion).
- Detects out-of-range select codes, substitutes a safe default, flags each event and counts it.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_INPUTS, 3, number of selectable inputs; legal range 2..16.
- DEFAULT_SEL, 0, input index used when sel is out of range; must be < NUM_INPUTS.
- ERRCNT_W, 16, width of the saturating error counter.
- Derived localparam SEL_W = max(1, clog2(NUM_INPUTS)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_INPUTS*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  input select code.
- in_valid  input  1  the current select/data is a real instruction.
- stall  input  1  hold the output register.
- flush  input  1  insert a bubble.
- out_data  output  WIDTH  registered selected operand.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  registered effective index actually used.
- sel_err  output  1  one-cycle pulse: the last capture had an out-of-range select.
- err_count  output  ERRCNT_W  saturating count of out-of-range captures.

Behaviour:
- Reset: while rst_n=0, out_data=0, out_valid=0, out_sel=0, sel_err=0, err_count=0.
  - Reset is asynchronous on assertion and released synchronously in effect (first capture at the first clk edge with rst_n=1).
  - Reset mid-stall or mid-flush discards all state.
- Effective select: eff_sel = sel when sel < NUM_INPUTS, else DEFAULT_SEL. picked = in_data[eff_sel]. This path is purely combinational.
- Latency: one clk from inputs to out_data/out_valid.
- Priority at each rising edge: flush > stall > capture.
  - flush=1 (stall ignored): out_valid<=0, out_data<=0, out_sel<=0, sel_err<=0, err_count unchanged.
  - stall=1, flush=0: out_data, out_valid and out_sel hold. sel_err<=0, so a pulse never repeats across stall cycles. err_count holds.
  - Otherwise (capture): out_data<=picked, out_valid<=in_valid, out_sel<=eff_sel.
    - out_data is captured even when in_valid=0.
    - sel_err<=(in_valid & sel>=NUM_INPUTS).
    - err_count increments by 1 under the same condition and saturates at 2^ERRCNT_W-1, with no wrap.
- An out-of-range sel with in_valid=0 is not an error: no pulse, no count.
- When NUM_INPUTS is a power of two, out-of-range is impossible; sel_err and err_count stay 0.
- flush does not clear err_count; only rst_n does.
- No X propagation: every output is driven from a register.

Decomposition:
- Shared package cpu_pkg holds:
  - forwarding select encodings FWD_REG=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2, used by the hazard unit as sel values;
  - ERRCNT_W default.
- One sub-module, mux_n: a purely combinational parametrised N:1 mux with out-of-range to DEFAULT_SEL substitution and an oor flag output.
- fwd_mux_stage instantiates mux_n and adds the register stage, stall/flush control and the error counter.

Test Plan:
- Reset and basic select (WIDTH=32, NUM_INPUTS=3):
  - Assert rst_n=0 mid-run -> all outputs 0 immediately.
  - Release, inputs {0x11111111, 0x22222222, 0x33333333}, sel=1, in_valid=1 -> next edge out_data=0x22222222, out_valid=1, out_sel=1, sel_err=0.
- Stall hold: capture sel=2, then stall=1 for 3 cycles while sel=0 and inputs change -> out_data stays 0x33333333, out_sel=2 throughout; releasing stall captures the new picked value on the next edge.
- Flush priority: stall=1 and flush=1 on the same edge -> out_valid=0, out_data=0, out_sel=0.
  - Following cycle with both low and in_valid=1, sel=0 -> out_data=0x11111111, out_valid=1.
- Out-of-range select: sel=3, in_valid=1 -> out_data=0x11111111 (DEFAULT_SEL=0), out_sel=0, sel_err=1 for exactly one cycle, err_count=1.
  - Same sel with stall=1 for 2 cycles -> no extra pulse, count stays 1.
  - sel=3 with in_valid=0 -> count stays 1.
- Counter saturation: ERRCNT_W=4, drive 20 consecutive valid out-of-range captures -> err_count reaches 15 and holds.
  - flush does not clear it; rst_n=0 does.
- Power-of-two config: NUM_INPUTS=4, SEL_W=2, sweep sel 0..3 -> out_data equals each input after 1 cycle, sel_err never asserts.
